exu_dmem_resp: RTL

//  Data-memory responder for the EXU load/store request port. Accepts a write or

---
 rtl/exu_dmem_resp.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/exu_dmem_resp.sv
// exu_dmem_resp: data-memory responder for the EXU load/store port.
// One request in flight, WAIT_CYC wait states, then a single response beat.
module exu_dmem_resp #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned WAIT_CYC   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_mem_wen,
   input  logic        i_mem_ren,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   input  logic [1:0]  i_mem_size,
   input  logic        i_mem_sign,
   output logic        o_mem_ready,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err
);

   localparam int unsigned AW       = DEPTH_LOG2 + 32'd2;
   localparam int unsigned DEPTH    = 32'd1 << DEPTH_LOG2;
   localparam logic [3:0]  LAST_CNT = (WAIT_CYC == 32'd0) ? 4'd0 : 4'(WAIT_CYC - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic req_error(input logic wen, input logic ren,
                                      input logic [1:0] size, input logic [31:0] addr);
      logic misalign;
      misalign = ((size == 2'b01) & addr[0]) | ((size == 2'b10) & (|addr[1:0]));
      return (wen & ren) | (size == 2'b11) | misalign | (addr[31:AW] != BASE_ADDR[31:AW]);
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [1:0] size, input logic sign);
      logic [31:0] sh;
      sh = word >> {lo, 3'b000};
      case (size)
         2'b00:   return {{24{sign & sh[7]}}, sh[7:0]};
         2'b01:   return {{16{sign & sh[15]}}, sh[15:0]};
         default: return word;
      endcase
   endfunction

   function automatic logic [3:0] wr_strobe(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   return 4'b0001 << lo;
         2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wr_lanes(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         2'b00:   return {4{wdata[7:0]}};
         2'b01:   return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   state_t                  state_r, next_s;
   logic [3:0]              cnt_r;
   logic                    cap_wen_r, cap_ren_r, cap_sign_r;
   logic [31:0]             cap_addr_r, cap_wdata_r;
   logic [1:0]              cap_size_r;
   logic                    ready_r, rsp_valid_r, rsp_err_r;
   logic [31:0]             rsp_rdata_r;
   logic [31:0]             mem_r [DEPTH];

   logic                    idle_s, accept_s, finish_s, err_s, do_write_s;
   logic                    req_wen_s, req_ren_s, req_sign_s;
   logic [31:0]             req_addr_s, req_wdata_s, rd_word_s, rd_data_s, wr_lanes_s;
   logic [1:0]              req_size_s;
   logic [3:0]              wr_strb_s;
   logic [DEPTH_LOG2-1:0]   idx_s;

   // In IDLE the live inputs are the request (zero-wait path); later the captured copy.
   assign idle_s      = (state_r == ST_IDLE);
   assign accept_s    = idle_s & (i_mem_wen | i_mem_ren);
   assign req_wen_s   = idle_s ? i_mem_wen   : cap_wen_r;
   assign req_ren_s   = idle_s ? i_mem_ren   : cap_ren_r;
   assign req_addr_s  = idle_s ? i_mem_addr  : cap_addr_r;
   assign req_wdata_s = idle_s ? i_mem_wdata : cap_wdata_r;
   assign req_size_s  = idle_s ? i_mem_size  : cap_size_r;
   assign req_sign_s  = idle_s ? i_mem_sign  : cap_sign_r;

   assign idx_s       = req_addr_s[AW-1:2];
   assign err_s       = req_error(req_wen_s, req_ren_s, req_size_s, req_addr_s);
   assign rd_word_s   = mem_r[idx_s];
   assign rd_data_s   = load_extend(rd_word_s, req_addr_s[1:0], req_size_s, req_sign_s);
   assign wr_strb_s   = wr_strobe(req_size_s, req_addr_s[1:0]);
   assign wr_lanes_s  = wr_lanes(req_size_s, req_wdata_s);
   assign finish_s    = (next_s == ST_RESP);
   assign do_write_s  = finish_s & req_wen_s & ~err_s & rst_n;

   // Next-state logic for the IDLE/WAIT/RESP sequencer.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_s = (WAIT_CYC == 32'd0) ? ST_RESP : ST_WAIT;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == LAST_CNT) begin
               next_s = ST_RESP;
            end else begin
               next_s = ST_WAIT;
            end
         end
         ST_RESP: next_s = ST_IDLE;
         default: next_s = ST_IDLE;
      endcase
   end

   // Sequencer state, request capture and registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         cap_wen_r   <= 1'b0;
         cap_ren_r   <= 1'b0;
         cap_addr_r  <= 32'd0;
         cap_wdata_r <= 32'd0;
         cap_size_r  <= 2'b00;
         cap_sign_r  <= 1'b0;
         ready_r     <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'd0;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r <= next_s;
         if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 4'd1;
         end else begin
            cnt_r <= 4'd0;
         end
         if (accept_s) begin
            cap_wen_r   <= i_mem_wen;
            cap_ren_r   <= i_mem_ren;
            cap_addr_r  <= i_mem_addr;
            cap_wdata_r <= i_mem_wdata;
            cap_size_r  <= i_mem_size;
            cap_sign_r  <= i_mem_sign;
         end
         ready_r     <= (next_s == ST_IDLE);
         rsp_valid_r <= finish_s;
         if (finish_s) begin
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s | req_wen_s) ? 32'd0 : rd_data_s;
         end
      end
   end

   // Byte-strobed array write on the edge entering RESP; contents are never reset.
   always_ff @(posedge clk) begin
      if (do_write_s) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb_s[b]) begin
               mem_r[idx_s][8*b +: 8] <= wr_lanes_s[8*b +: 8];
            end
         end
      end
   end

   assign o_mem_ready = ready_r;
   assign o_rsp_valid = rsp_valid_r;
   assign o_rsp_rdata = rsp_rdata_r;
   assign o_rsp_err   = rsp_err_r;

endmodule
